zube_z80_bus_ctrl: RTL and testbench

//   Sequences Z80 I/O bus cycles for the zube mailbox. Synchronises the asynchronous Z80 control pins into clk.

---
 rtl/zube_pkg.sv | 18 +
 rtl/zube_sync.sv | 29 ++
 rtl/zube_z80_bus_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_zube_z80_bus_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zube_pkg.sv
// Shared types and constants for the zube Z80 mailbox bus controller.
package zube_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        HOLD  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    function automatic logic port_match(input logic [6:0] addr_hi, input logic [6:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

// File: rtl/zube_sync.sv
// N-stage single-bit synchroniser with a configurable reset value.
module zube_sync #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[N-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            chain_q <= {N{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[N-1];

endmodule

// File: rtl/zube_z80_bus_ctrl.sv
// Z80 I/O cycle sequencer for the zube mailbox: synchronises the Z80 strobes,
// decodes IN/OUT to the port pair, owns the data-bus direction and issues strobes.
module zube_z80_bus_ctrl
    import zube_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DRIVE_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       enable,
    input  logic [7:0] port_base,
    input  logic [7:0] z80_address_bus,
    input  logic [7:0] z80_data_bus_in,
    input  logic       z80_read_strobe_b,
    input  logic       z80_write_strobe_b,
    input  logic       z80_m1,
    input  logic       z80_ioreq_b,
    output logic [7:0] z80_data_bus_out,
    output logic       z80_bus_dir,
    input  logic [7:0] reg_data_rd,
    input  logic [7:0] reg_status_rd,
    output logic       rd_pulse,
    output logic       wr_pulse,
    output logic       reg_sel,
    output logic [7:0] wr_data,
    output logic       cycle_err
);

    localparam logic [2:0] HOLD_LAST = 3'(DRIVE_HOLD);

    logic rst_b_s;
    logic rd_s, wr_s, m1_s, ioreq_s;
    logic unused_base;

    assign unused_base = port_base[0];

    // Reset asserts asynchronously but releases on a clk edge.
    zube_sync #(.N(2), .RESET_VAL(1'b0)) u_rst_sync (
        .clk(clk), .reset_b(reset_b), .d(1'b1), .q(rst_b_s));

    zube_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_rd_sync (
        .clk(clk), .reset_b(rst_b_s), .d(z80_read_strobe_b), .q(rd_s));
    zube_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_wr_sync (
        .clk(clk), .reset_b(rst_b_s), .d(z80_write_strobe_b), .q(wr_s));
    zube_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_m1_sync (
        .clk(clk), .reset_b(rst_b_s), .d(z80_m1), .q(m1_s));
    zube_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_ioreq_sync (
        .clk(clk), .reset_b(rst_b_s), .d(z80_ioreq_b), .q(ioreq_s));

    state_t     state_q, state_d;
    logic       stall_q, stall_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       bus_dir_q, bus_dir_d;
    logic       reg_sel_q, reg_sel_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_pulse_q, rd_pulse_d;
    logic       wr_pulse_q, wr_pulse_d;
    logic       err_q, err_d;

    logic hit, rd_start, wr_start, both_low, hold_done;

    // INTA (M1_n and IORQ_n both low) is never treated as a mailbox access.
    assign hit       = enable & ~ioreq_s & m1_s &
                       port_match(z80_address_bus[7:1], port_base[7:1]);
    assign rd_start  = hit & ~rd_s & wr_s;
    assign wr_start  = hit & ~wr_s & rd_s;
    assign both_low  = hit & ~rd_s & ~wr_s;
    assign hold_done = (cnt_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_b_s) begin
        if (!rst_b_s) begin
            state_q    <= IDLE;
            stall_q    <= 1'b0;
            cnt_q      <= 3'd0;
            data_out_q <= 8'h00;
            bus_dir_q  <= 1'b0;
            reg_sel_q  <= 1'b0;
            wr_data_q  <= 8'h00;
            rd_pulse_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            bus_dir_q  <= bus_dir_d;
            reg_sel_q  <= reg_sel_d;
            wr_data_q  <= wr_data_d;
            rd_pulse_q <= rd_pulse_d;
            wr_pulse_q <= wr_pulse_d;
            err_q      <= err_d;
        end
    end

    // After a both-strobes-low error, stall until both strobes are released.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        unique case (state_q)
            IDLE: begin
                if (stall_q) begin
                    stall_d = ~(rd_s & wr_s);
                end else if (both_low) begin
                    stall_d = 1'b1;
                end else if (rd_start) begin
                    state_d = READ;
                end else if (wr_start) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (rd_s) begin
                    state_d = HOLD;
                end else if (ioreq_s) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        bus_dir_d  = bus_dir_q;
        reg_sel_d  = reg_sel_q;
        wr_data_d  = wr_data_q;
        rd_pulse_d = 1'b0;
        wr_pulse_d = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!stall_q) begin
                    if (both_low) begin
                        err_d = 1'b1;
                    end else if (rd_start) begin
                        reg_sel_d  = z80_address_bus[0];
                        data_out_d = (z80_address_bus[0] == REG_DATA) ? reg_data_rd : reg_status_rd;
                        bus_dir_d  = 1'b1;
                    end else if (wr_start) begin
                        reg_sel_d  = z80_address_bus[0];
                        wr_data_d  = z80_data_bus_in;
                        wr_pulse_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_s) begin
                    rd_pulse_d = 1'b1;
                    cnt_d      = 3'd0;
                end else if (ioreq_s) begin
                    err_d     = 1'b1;
                    bus_dir_d = 1'b0;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    bus_dir_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign z80_data_bus_out = data_out_q;
    assign z80_bus_dir      = bus_dir_q;
    assign reg_sel          = reg_sel_q;
    assign wr_data          = wr_data_q;
    assign rd_pulse         = rd_pulse_q;
    assign wr_pulse         = wr_pulse_q;
    assign cycle_err        = err_q;

endmodule

// File: tb/tb_zube_z80_bus_ctrl.sv
// Scoreboard-driven bench for zube_z80_bus_ctrl: Z80 IN/OUT cycles, misses, aborts and reset.
module tb_zube_z80_bus_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int DRIVE_HOLD  = 2;

    localparam logic [2:0] EV_RD  = 3'b001;
    localparam logic [2:0] EV_WR  = 3'b010;
    localparam logic [2:0] EV_ERR = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic       sel;
        logic [7:0] data;
    } event_t;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       enable;
    logic [7:0] port_base;
    logic [7:0] z80_address_bus;
    logic [7:0] z80_data_bus_in;
    logic       z80_read_strobe_b;
    logic       z80_write_strobe_b;
    logic       z80_m1;
    logic       z80_ioreq_b;
    logic [7:0] z80_data_bus_out;
    logic       z80_bus_dir;
    logic [7:0] reg_data_rd;
    logic [7:0] reg_status_rd;
    logic       rd_pulse;
    logic       wr_pulse;
    logic       reg_sel;
    logic [7:0] wr_data;
    logic       cycle_err;

    int     checks = 0;
    int     errors = 0;
    event_t sb[$];
    logic   busdir_seen;

    always #5 clk = ~clk;

    zube_z80_bus_ctrl #(.SYNC_STAGES(SYNC_STAGES), .DRIVE_HOLD(DRIVE_HOLD)) dut (
        .clk(clk), .reset_b(reset_b), .enable(enable), .port_base(port_base),
        .z80_address_bus(z80_address_bus), .z80_data_bus_in(z80_data_bus_in),
        .z80_read_strobe_b(z80_read_strobe_b), .z80_write_strobe_b(z80_write_strobe_b),
        .z80_m1(z80_m1), .z80_ioreq_b(z80_ioreq_b),
        .z80_data_bus_out(z80_data_bus_out), .z80_bus_dir(z80_bus_dir),
        .reg_data_rd(reg_data_rd), .reg_status_rd(reg_status_rd),
        .rd_pulse(rd_pulse), .wr_pulse(wr_pulse), .reg_sel(reg_sel),
        .wr_data(wr_data), .cycle_err(cycle_err));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every pulse the DUT produces is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_b) begin
            if (z80_bus_dir) busdir_seen = 1'b1;
            if (rd_pulse || wr_pulse || cycle_err) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", {29'd0, cycle_err, wr_pulse, rd_pulse}, 32'd0);
                end else begin
                    event_t e;
                    e = sb.pop_front();
                    checkOutput("event_kind", {29'd0, cycle_err, wr_pulse, rd_pulse}, {29'd0, e.kind});
                    if (e.kind == EV_RD) begin
                        checkOutput("rd_sel", {31'd0, reg_sel}, {31'd0, e.sel});
                        checkOutput("rd_data_out", {24'd0, z80_data_bus_out}, {24'd0, e.data});
                    end else if (e.kind == EV_WR) begin
                        checkOutput("wr_sel", {31'd0, reg_sel}, {31'd0, e.sel});
                        checkOutput("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                    end
                end
            end
        end
    end

    function automatic event_t mkEv(input logic [2:0] kind, input logic sel, input logic [7:0] data);
        event_t e;
        e.kind = kind;
        e.sel  = sel;
        e.data = data;
        return e;
    endfunction

    task automatic idleBus(input int n);
        z80_read_strobe_b  = 1'b1;
        z80_write_strobe_b = 1'b1;
        z80_ioreq_b        = 1'b1;
        z80_m1             = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // mid_action: 0 none, 1 drop enable, 2 move port_base, applied while the strobe is low.
    task automatic applyStimulus(input bit is_write, input logic [7:0] addr, input logic [7:0] data,
                                 input int low_clks, input int mid_action);
        @(negedge clk);
        z80_address_bus = addr;
        z80_data_bus_in = data;
        z80_ioreq_b     = 1'b0;
        @(negedge clk);
        if (is_write) z80_write_strobe_b = 1'b0;
        else          z80_read_strobe_b  = 1'b0;
        for (int i = 0; i < low_clks; i++) begin
            @(negedge clk);
            if (i == SYNC_STAGES + 2) begin
                if (mid_action == 1) enable = 1'b0;
                if (mid_action == 2) port_base = 8'h80;
            end
        end
        z80_read_strobe_b  = 1'b1;
        z80_write_strobe_b = 1'b1;
        @(negedge clk);
        z80_ioreq_b = 1'b1;
        idleBus(8);
    endtask

    task automatic waitBusDir(input logic val, output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (z80_bus_dir == val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset_b            = 1'b0;
        enable             = 1'b1;
        port_base          = 8'h40;
        z80_address_bus    = 8'h00;
        z80_data_bus_in    = 8'h00;
        z80_read_strobe_b  = 1'b1;
        z80_write_strobe_b = 1'b1;
        z80_m1             = 1'b1;
        z80_ioreq_b        = 1'b1;
        reg_data_rd        = 8'h3C;
        reg_status_rd      = 8'h81;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_bus_dir", {31'd0, z80_bus_dir}, 32'd0);
        checkOutput("rst_data_out", {24'd0, z80_data_bus_out}, 32'd0);
        checkOutput("rst_pulses", {29'd0, cycle_err, wr_pulse, rd_pulse}, 32'd0);
        checkOutput("rst_wr_data", {24'd0, wr_data}, 32'd0);
        checkOutput("rst_reg_sel", {31'd0, reg_sel}, 32'd0);

        $display("[TB] OUT (0x40),0xA5");
        busdir_seen = 1'b0;
        sb.push_back(mkEv(EV_WR, 1'b0, 8'hA5));
        applyStimulus(1'b1, 8'h40, 8'hA5, 6, 0);
        checkOutput("out_busdir_never", {31'd0, busdir_seen}, 32'd0);

        $display("[TB] IN (0x41) timing and freeze");
        reg_status_rd = 8'h81;
        sb.push_back(mkEv(EV_RD, 1'b1, 8'h81));
        @(negedge clk);
        z80_address_bus = 8'h41;
        z80_ioreq_b     = 1'b0;
        @(negedge clk);
        z80_read_strobe_b = 1'b0;
        waitBusDir(1'b1, n);
        checkOutput("in_busdir_latency", n, SYNC_STAGES + 1);
        checkOutput("in_data_out", {24'd0, z80_data_bus_out}, 32'h81);
        reg_status_rd = 8'h00;
        repeat (3) @(negedge clk);
        z80_read_strobe_b = 1'b1;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) z80_ioreq_b = 1'b1;
            if (rd_pulse) begin
                n = i;
                break;
            end
        end
        checkOutput("in_rd_latency", n, SYNC_STAGES + 1);
        waitBusDir(1'b0, n);
        checkOutput("in_hold_len", n, DRIVE_HOLD + 1);
        idleBus(6);

        $display("[TB] IN (0x40) data register");
        reg_data_rd = 8'h5E;
        sb.push_back(mkEv(EV_RD, 1'b0, 8'h5E));
        applyStimulus(1'b0, 8'h40, 8'h00, 6, 0);

        $display("[TB] miss and INTA");
        busdir_seen = 1'b0;
        applyStimulus(1'b0, 8'h50, 8'h00, 6, 0);
        @(negedge clk);
        z80_address_bus = 8'h40;
        z80_m1          = 1'b0;
        z80_ioreq_b     = 1'b0;
        z80_read_strobe_b = 1'b0;
        repeat (8) @(negedge clk);
        idleBus(8);
        checkOutput("miss_inta_busdir", {31'd0, busdir_seen}, 32'd0);

        $display("[TB] abort");
        sb.push_back(mkEv(EV_ERR, 1'b0, 8'h00));
        @(negedge clk);
        z80_address_bus = 8'h40;
        z80_ioreq_b     = 1'b0;
        @(negedge clk);
        z80_read_strobe_b = 1'b0;
        waitBusDir(1'b1, n);
        checkOutput("abort_busdir_up", n, SYNC_STAGES + 1);
        z80_ioreq_b = 1'b1;
        waitBusDir(1'b0, n);
        checkOutput("abort_busdir_down", n, SYNC_STAGES + 1);
        repeat (3) @(negedge clk);
        idleBus(8);

        $display("[TB] enable low and enable drop mid-write");
        busdir_seen = 1'b0;
        enable = 1'b0;
        applyStimulus(1'b0, 8'h40, 8'h00, 6, 0);
        checkOutput("disabled_busdir", {31'd0, busdir_seen}, 32'd0);
        enable = 1'b1;
        sb.push_back(mkEv(EV_WR, 1'b1, 8'hC3));
        applyStimulus(1'b1, 8'h41, 8'hC3, 12, 1);
        enable = 1'b1;

        $display("[TB] port_base move mid-write and both strobes low");
        sb.push_back(mkEv(EV_WR, 1'b1, 8'h5A));
        applyStimulus(1'b1, 8'h41, 8'h5A, 8, 2);
        port_base = 8'h40;
        sb.push_back(mkEv(EV_ERR, 1'b0, 8'h00));
        @(negedge clk);
        z80_address_bus = 8'h40;
        z80_ioreq_b     = 1'b0;
        @(negedge clk);
        z80_read_strobe_b  = 1'b0;
        z80_write_strobe_b = 1'b0;
        repeat (8) @(negedge clk);
        idleBus(8);

        $display("[TB] reset during READ");
        reg_data_rd = 8'h77;
        @(negedge clk);
        z80_address_bus = 8'h40;
        z80_ioreq_b     = 1'b0;
        @(negedge clk);
        z80_read_strobe_b = 1'b0;
        waitBusDir(1'b1, n);
        checkOutput("rst_read_busdir_up", n, SYNC_STAGES + 1);
        reset_b = 1'b0;
        #1;
        checkOutput("rst_mid_bus_dir", {31'd0, z80_bus_dir}, 32'd0);
        checkOutput("rst_mid_data_out", {24'd0, z80_data_bus_out}, 32'd0);
        checkOutput("rst_mid_pulses", {29'd0, cycle_err, wr_pulse, rd_pulse}, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        idleBus(8);
        sb.push_back(mkEv(EV_WR, 1'b0, 8'h11));
        applyStimulus(1'b1, 8'h40, 8'h11, 6, 0);

        checkOutput("sb_leftover", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
